// File: rtl/alu_mul_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module   : alu_mul_ctrl_if
//  Purpose  : Request/result and shared-ALU signals of the multiply sequencer.
//             The slave modport is the sequencer. The master modport is the
//             issue logic plus the ALU that returns aluResult.
//             The optional ovf signal exists only when ALU_MUL_OVF_EN is
//             defined.
//  Revision : 1.0  initial release
// ============================================================================
interface alu_mul_ctrl_if #(
    parameter int WIDTH = 64
);
    logic             start;
    logic [WIDTH-1:0] mcand;
    logic [WIDTH-1:0] mplier;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] product;
    logic [2:0]       aluOP;
    logic [WIDTH-1:0] aluA;
    logic [WIDTH-1:0] aluB;
    logic [WIDTH-1:0] aluResult;
`ifdef ALU_MUL_OVF_EN
    logic             ovf;

    modport slave (
        input  start, mcand, mplier, aluResult,
        output busy, done, product, aluOP, aluA, aluB, ovf
    );
    modport master (
        output start, mcand, mplier, aluResult,
        input  busy, done, product, aluOP, aluA, aluB, ovf
    );
`else
    modport slave (
        input  start, mcand, mplier, aluResult,
        output busy, done, product, aluOP, aluA, aluB
    );
    modport master (
        output start, mcand, mplier, aluResult,
        input  busy, done, product, aluOP, aluA, aluB
    );
`endif
endinterface
`default_nettype wire

// File: rtl/alu_mul_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : alu_mul_ctrl
//  Purpose  : Shift-and-add multiply sequencer. It borrows the shared ALU for
//             its add and shift steps and returns the low WIDTH bits of
//             mcand*mplier.
//             Optional macro ALU_MUL_OVF_EN adds a sticky unsigned overflow
//             flag, bus.ovf.
//  Revision : 1.0  initial release
// ============================================================================
module alu_mul_ctrl #(
    parameter int WIDTH     = 64,
    parameter int SHAMT_LSB = 10
) (
    input  logic          clk,
    input  logic          rst_n,
    alu_mul_ctrl_if.slave bus
);
    localparam logic [2:0]       c_op_add    = 3'b000;
    localparam logic [2:0]       c_op_lsl    = 3'b101;
    // ALU operand B that encodes a left shift of exactly one bit.
    localparam logic [WIDTH-1:0] c_shift_one = {{(WIDTH-1){1'b0}}, 1'b1} << SHAMT_LSB;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ADD   = 2'd1,
        S_SHIFT = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [WIDTH-1:0] r_acc;
    logic [WIDTH-1:0] r_mc;
    logic [WIDTH-1:0] r_mp;
    logic [WIDTH-1:0] r_product;
    logic [WIDTH-1:0] w_mp_shr;

    // The multiplier after the shift that is in progress. Once this is zero, no
    // further partial products remain.
    assign w_mp_shr = r_mp >> 1;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode. A multiplier bit that is set costs an ADD plus a
    // SHIFT. A clear bit costs only a SHIFT.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (bus.start) begin
                    if (bus.mplier == '0)   w_state_nxt = S_DONE;
                    else if (bus.mplier[0]) w_state_nxt = S_ADD;
                    else                    w_state_nxt = S_SHIFT;
                end
            end
            S_ADD:   w_state_nxt = S_SHIFT;
            S_SHIFT: begin
                if (w_mp_shr == '0)   w_state_nxt = S_DONE;
                else if (w_mp_shr[0]) w_state_nxt = S_ADD;
                else                  w_state_nxt = S_SHIFT;
            end
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Shared-ALU drive. In IDLE and DONE this is the idle drive: an add of
    // zeros.
    always_comb begin
        bus.aluOP = c_op_add;
        bus.aluA  = '0;
        bus.aluB  = '0;
        case (r_state)
            S_ADD: begin
                bus.aluOP = c_op_add;
                bus.aluA  = r_acc;
                bus.aluB  = r_mc;
            end
            S_SHIFT: begin
                bus.aluOP = c_op_lsl;
                bus.aluA  = r_mc;
                bus.aluB  = c_shift_one;
            end
            default: ;
        endcase
    end

    // Datapath. Operands are captured on an accepted start and then stepped
    // using the ALU result. product is loaded on the edge that enters DONE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc     <= '0;
            r_mc      <= '0;
            r_mp      <= '0;
            r_product <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        r_acc <= '0;
                        r_mc  <= bus.mcand;
                        r_mp  <= bus.mplier;
                        if (bus.mplier == '0) r_product <= '0;
                    end
                end
                S_ADD:   r_acc <= bus.aluResult;
                S_SHIFT: begin
                    r_mc <= bus.aluResult;
                    r_mp <= w_mp_shr;
                    if (w_mp_shr == '0) r_product <= r_acc;
                end
                default: ;
            endcase
        end
    end

`ifdef ALU_MUL_OVF_EN
    logic r_ovf;

    // Sticky unsigned overflow. It is set by a carry out of an ADD, or by a
    // shift that drops a set MSB while later partial products still remain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ovf <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE:  if (bus.start) r_ovf <= 1'b0;
                S_ADD:   if (bus.aluResult < r_acc) r_ovf <= 1'b1;
                S_SHIFT: if (r_mc[WIDTH-1] && (w_mp_shr != '0)) r_ovf <= 1'b1;
                default: ;
            endcase
        end
    end

    assign bus.ovf = r_ovf;
`endif

    assign bus.busy    = (r_state != S_IDLE);
    assign bus.done    = (r_state == S_DONE);
    assign bus.product = r_product;

endmodule
`default_nettype wire

// File: doc/alu_mul_ctrl.md
Name: alu_mul_ctrl

Overview:
- Iterative shift-and-add multiply sequencer that borrows the shared 64-bit ALU for its add and shift steps.
- Sits beside the ALU in the execute stage and drives aluOP/A/B through the execute-stage operand mux while busy is high.
- Produces the low 64 bits of A*B, which are correct for both signed and unsigned operands.
- Issue logic stalls the pipeline while busy is high.

Parameters:
- WIDTH, 64, operand, product and ALU data width.
- SHAMT_LSB, 10, LSB of the ALU shift-amount field in operand B; the shift amount is B[SHAMT_LSB+5:SHAMT_LSB].

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  request; sampled only in IDLE.
- mcand  in  WIDTH  multiplicand; captured on an accepted start.
- mplier  in  WIDTH  multiplier; captured on an accepted start.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse; product is valid from this cycle.
- product  out  WIDTH  result register; held until the next accepted start.
- aluOP  out  3  ALU opcode: 000 add, 101 LSL.
- aluA  out  WIDTH  ALU operand A.
- aluB  out  WIDTH  ALU operand B.
- aluResult  in  WIDTH  combinational ALU result, consumed in the same cycle it is driven.

Behaviour:
- Reset (rst_n=0, asynchronous): state=IDLE; busy=0, done=0, product=0. Internal acc, mc and mp cleared. ALU outputs driven idle.
- Reset mid-operation aborts immediately, with no done pulse.
- Idle ALU drive, used in IDLE and DONE: aluOP=000, aluA=0, aluB=0.
- ALU outputs are combinational decodes of state and registers.
- IDLE:
  - start=1: acc<=0, mc<=mcand, mp<=mplier.
  - Next state: DONE if mplier==0; else ADD if mplier[0]; else SHIFT.
- ADD:
  - Drive aluOP=000, aluA=acc, aluB=mc.
  - acc<=aluResult; next state SHIFT.
- SHIFT:
  - Drive aluOP=101, aluA=mc, aluB=1<<SHAMT_LSB (shift amount 1).
  - mc<=aluResult; mp<=mp>>1 (logical shift, internal, no ALU use).
  - With mp'=mp>>1: next state DONE if mp'==0; else ADD if mp'[0]; else SHIFT.
- DONE: done=1, product<=acc is visible this cycle (registered on entry); next state IDLE.
- Latency: done is high N cycles after the start edge, N = popcount(mplier) + bitlen(mplier) + 1, where bitlen(0)=0.
  - Maximum N = 129, for mplier with bit 63 set and all bits set.
  - Back-to-back: the earliest next start is accepted in the IDLE cycle after DONE.
- start while busy: ignored, not queued. mcand/mplier changes while busy: no effect.
- Arithmetic: all ALU results are taken modulo 2^WIDTH. Negative mplier iterates all 64 bits, giving the correct two's-complement low product.

Optional Feature:
- Macro: ALU_MUL_OVF_EN.
- Defined:
  - Adds output port ovf (1 bit, reset 0, sticky, cleared on an accepted start).
  - ovf is set on unsigned overflow:
    - in ADD when aluResult < acc (unsigned carry-out); or
    - in SHIFT when mc[WIDTH-1]==1 and mp'!=0 (a shifted-out bit would still be added).
  - ovf is valid with done.
- Undefined: port and logic absent; all other behaviour identical.

Test Plan:
- Reset mid-op: start mcand=5, mplier=0xFF, drop rst_n at cycle 4 -> busy=0, product=0, no done; a following start mcand=2, mplier=2 -> product=4.
- Basic: mcand=7, mplier=3 -> ADD,SHIFT,ADD,SHIFT; done at cycle 5, product=21; aluOP sequence 000,101,000,101; aluB=0x400 on shifts.
- Zero multiplier: mcand=0x1234, mplier=0 -> done at cycle 1, product=0, no ALU ops issued.
- Signed: mcand=-3 (0xFFFF_FFFF_FFFF_FFFD), mplier=4 -> done at cycle 5, product=0xFFFF_FFFF_FFFF_FFF4; then mcand=6, mplier=-1 -> done at cycle 129, product=-6.
- Ignored start: pulse start with mcand=9, mplier=9 while busy on 7*3 -> product=21; busy falls after done; no second done.
- ALU_MUL_OVF_EN: mcand=2^63, mplier=2 -> ovf=1, product=0; mcand=3, mplier=5 -> ovf=0, product=15.
